timebase_alarm_sched: RTL and testbench
=======================================

Name: timebase_alarm_sched

Overview:
Owns the team's free-running 42-bit timebase counter and shares it between NUM_CH requesters as one-shot alarm channels. Each requester submits a relative delay over a valid/ready handshake, and a round-robin arbiter grants at most one request per cycle. On a grant, the channel latches an absolute deadline and emits a single-cycle fire pulse when the timebase reaches it. The block sits between the system timebase and the sequencing logic that needs timed events.

Parameters:
NUM_CH, 4, number of alarm channels/requesters (2..16)
CNT_W, 42, timebase and delay width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
cnt_en  in  1  timebase advances by 1 when high
cnt_load  in  1  load timebase from cnt_load_val
cnt_load_val  in  CNT_W  timebase load value
count  out  CNT_W  current timebase value (register)
req_valid  in  NUM_CH  per-channel arm request
req_delay  in  NUM_CH*CNT_W  per-channel relative delay; channel i at [i*CNT_W +: CNT_W]
req_ready  out  NUM_CH  one-hot grant, combinational from valid/state/pointer
cancel  in  NUM_CH  disarm channel
armed  out  NUM_CH  channel ARMED flag (register)
fire  out  NUM_CH  one-cycle alarm pulse (register)

Behaviour:
- Reset (rst==0 at posedge): count=0, armed=0, fire=0, RR pointer=0; all channels IDLE.
- Timebase:
  - cnt_load has priority: count<=cnt_load_val.
  - Otherwise, if cnt_en is high: count<=count+1, modulo 2^CNT_W; wraps all-ones to 0.
  - Otherwise: count holds.
- Channel FSM, per channel: IDLE -> ARMED on grant; ARMED -> IDLE on match or cancel. There is no other state.
- Eligibility: channel i is eligible when req_valid[i]==1 and the channel is IDLE.
- Arbiter:
  - Round-robin over eligible channels, starting the search at the pointer.
  - At most one req_ready bit is high per cycle; req_ready is 0 when nothing is eligible.
  - After a grant to channel g, the pointer becomes (g+1) mod NUM_CH. With no grant, the pointer holds.
- Grant at cycle t with count==C and delay D:
  - Channel stores deadline=(C+Deff) mod 2^CNT_W, where Deff = (D==0) ? 1 : D.
  - armed[i]=1 from t+1.
- Match: in a cycle where a channel is ARMED, count==deadline, and cancel[i]==0:
  - Next cycle: fire[i]=1 for exactly one cycle, armed[i]=0.
  - With cnt_en held high and no load, latency from grant to fire is Deff+1 cycles.
- cancel[i] on an ARMED channel: next cycle armed[i]=0, and no fire occurs even if count==deadline in the same cycle (cancel wins).
- cancel on an IDLE channel is ignored; a simultaneous request on that channel may still be granted.
- Counter halted (cnt_en=0): a match still fires if count already equals the deadline. Otherwise firing is deferred.
- cnt_load while ARMED: stored deadlines are unchanged. Comparison is equality only, so a load that jumps past a deadline defers firing until the count wraps around to it.
- Multiple channels may fire in the same cycle.
- A fired channel is eligible for a new grant in the same cycle its fire pulse is high.
- Reset mid-operation: all alarms are discarded, and no fire is generated on the cycle after reset.

Optional Feature:
TIMEBASE_PERIODIC_EN
- Defined:
  - On a grant, the channel also stores Deff as its period.
  - On a match, the channel fires and stays ARMED with deadline<=deadline+period (mod 2^CNT_W).
  - Only cancel or reset returns the channel to IDLE.
- Undefined: one-shot behaviour as above; no period storage is synthesized.

Decomposition:
- Shared package timebase_pkg holds:
  - localparam CNT_W_DEF=42
  - typedef enum {CH_IDLE, CH_ARMED} ch_state_t
  - typedef logic [CNT_W_DEF-1:0] tb_t
- One sub-module, rr_arbiter: request and grant vectors of parameter width N plus the rotating pointer. It is instantiated once.
- Channel storage and compare logic are a generate loop inside the top.

Test Plan:
- Reset then cnt_en=1 for 10 cycles -> count==10; armed=0; fire=0.
- cnt_en=1; ch0 requests D=5 at count=100 -> req_ready=0001; armed[0]=1; count==105 one cycle; fire[0] pulses the next cycle; armed[0]=0.
- req_valid=1111 held with D=1000 each, pointer=0 -> grants ch0, ch1, ch2, ch3 on 4 consecutive cycles.
- ch2 armed with deadline 50; cancel[2] asserted while count==50 -> no fire[2]; armed[2]=0.
- cnt_load_val=2^42-2, load, then ch1 D=4 -> deadline=2; count wraps through 0 -> fire[1] after count==2.
- With TIMEBASE_PERIODIC_EN: ch3 D=3 -> fire[3] every 3 cycles for 4 periods; cancel -> pulses stop; D=0 -> fire every cycle.

Source files
------------

// File: rtl/timebase_pkg.sv
// Shared types for the timebase alarm scheduler (optional build macro: TIMEBASE_PERIODIC_EN).
package timebase_pkg;

  localparam int CNT_W_DEF = 42;

  typedef enum logic {CH_IDLE, CH_ARMED} ch_state_t;

  typedef logic [CNT_W_DEF-1:0] tb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer; pointer moves past each winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gidx;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        w_found    = 1'b1;
        w_gidx     = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + PW'(1);
    end
  end

endmodule

// File: rtl/timebase_alarm_sched.sv
// Free-running timebase shared by NUM_CH alarm channels; define TIMEBASE_PERIODIC_EN for periodic re-arming.
module timebase_alarm_sched
  import timebase_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cnt_en,
  input  logic                    cnt_load,
  input  logic [CNT_W-1:0]        cnt_load_val,
  output logic [CNT_W-1:0]        count,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*CNT_W-1:0] req_delay,
  output logic [NUM_CH-1:0]       req_ready,
  input  logic [NUM_CH-1:0]       cancel,
  output logic [NUM_CH-1:0]       armed,
  output logic [NUM_CH-1:0]       fire
);

  logic [CNT_W-1:0]  r_count;
  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_gnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (cnt_load) begin
      r_count <= cnt_load_val;
    end else if (cnt_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count     = r_count;
  assign req_ready = w_gnt;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_elig),
    .o_gnt (w_gnt)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ch_state_t        r_state;
      ch_state_t        w_state_next;
      logic [CNT_W-1:0] r_deadline;
      logic [CNT_W-1:0] w_deadline_next;
      logic [CNT_W-1:0] w_delay;
      logic [CNT_W-1:0] w_deff;
      logic             w_match;
      logic             r_fire;
`ifdef TIMEBASE_PERIODIC_EN
      logic [CNT_W-1:0] r_period;
      logic [CNT_W-1:0] w_period_next;
`endif

      assign w_delay = req_delay[gi*CNT_W +: CNT_W];
      // A zero delay would equal the current count and be missed by the next cycle's compare.
      assign w_deff  = (w_delay == '0) ? CNT_W'(1) : w_delay;
      assign w_match = (r_state == CH_ARMED) && (r_count == r_deadline);

      assign w_elig[gi] = req_valid[gi] && (r_state == CH_IDLE);
      assign armed[gi]  = (r_state == CH_ARMED);
      assign fire[gi]   = r_fire;

      always_comb begin
        w_state_next    = r_state;
        w_deadline_next = r_deadline;
`ifdef TIMEBASE_PERIODIC_EN
        w_period_next   = r_period;
`endif
        case (r_state)
          CH_IDLE: begin
            if (w_gnt[gi]) begin
              w_state_next    = CH_ARMED;
              w_deadline_next = r_count + w_deff;
`ifdef TIMEBASE_PERIODIC_EN
              w_period_next   = w_deff;
`endif
            end
          end
          CH_ARMED: begin
            if (cancel[gi]) begin
              w_state_next = CH_IDLE;
            end else if (w_match) begin
`ifdef TIMEBASE_PERIODIC_EN
              w_deadline_next = r_deadline + r_period;
`else
              w_state_next    = CH_IDLE;
`endif
            end
          end
          default: w_state_next = CH_IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_state <= CH_IDLE;
          r_fire  <= 1'b0;
        end else begin
          r_state <= w_state_next;
          r_fire  <= w_match && !cancel[gi];
        end
      end

      // Deadline/period are only meaningful while ARMED, so they carry no reset.
      always_ff @(posedge clk) begin
        r_deadline <= w_deadline_next;
`ifdef TIMEBASE_PERIODIC_EN
        r_period   <= w_period_next;
`endif
      end
    end
  endgenerate

endmodule

// File: tb/tb_timebase_alarm_sched.sv
// Directed self-checking bench for timebase_alarm_sched; periodic steps run when TIMEBASE_PERIODIC_EN is defined.
module tb_timebase_alarm_sched;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 42;

  logic                    clk;
  logic                    rst;
  logic                    cnt_en;
  logic                    cnt_load;
  logic [CNT_W-1:0]        cnt_load_val;
  logic [CNT_W-1:0]        count;
  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH*CNT_W-1:0] req_delay;
  logic [NUM_CH-1:0]       req_ready;
  logic [NUM_CH-1:0]       cancel;
  logic [NUM_CH-1:0]       armed;
  logic [NUM_CH-1:0]       fire;

  int n_assert = 0;
  int n_fail   = 0;

  timebase_alarm_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cnt_en       (cnt_en),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .count        (count),
    .req_valid    (req_valid),
    .req_delay    (req_delay),
    .req_ready    (req_ready),
    .cancel       (cancel),
    .armed        (armed),
    .fire         (fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_delay(input int ch, input logic [CNT_W-1:0] d);
    req_delay[ch*CNT_W +: CNT_W] = d;
  endtask

  logic [CNT_W-1:0] top_val;

  initial begin
    rst = 1'b0; cnt_en = 1'b0; cnt_load = 1'b0; cnt_load_val = '0;
    req_valid = '0; req_delay = '0; cancel = '0;
    tick(); tick();
    chk("reset_count", count, 0);
    chk("reset_armed", armed, 0);
    chk("reset_fire", fire, 0);

    // free run
    rst = 1'b1; cnt_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("run10_count", count, 10);
    chk("run10_armed", armed, 0);
    chk("run10_fire", fire, 0);

    // one-shot ch0, D=5 at count 100
    cnt_load = 1'b1; cnt_load_val = 100;
    tick();
    cnt_load = 1'b0;
    chk("load100", count, 100);
    req_valid = 4'b0001; set_delay(0, 5);
    #1 chk("ch0_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("ch0_armed", armed, 4'b0001);
    for (int i = 0; i < 4; i++) tick();
    chk("ch0_cnt105", count, 105);
    chk("ch0_nofire_yet", fire, 0);
    tick();
    chk("ch0_fire", fire, 4'b0001);
    chk("ch0_disarm", armed, 0);
    tick();
    chk("ch0_fire_1cyc", fire, 0);

    // reset to bring pointer to 0, then four-way contention
    rst = 1'b0; tick(); rst = 1'b1;
    chk("rst2_count", count, 0);
    req_valid = 4'b1111;
    for (int c = 0; c < NUM_CH; c++) set_delay(c, 1000);
    #1 chk("rr_g0", req_ready, 4'b0001);
    tick(); chk("rr_g1", req_ready, 4'b0010);
    tick(); chk("rr_g2", req_ready, 4'b0100);
    tick(); chk("rr_g3", req_ready, 4'b1000);
    tick();
    chk("rr_all_armed", armed, 4'b1111);
    chk("rr_none_ready", req_ready, 0);
    req_valid = '0;
    // reset mid-operation discards alarms
    rst = 1'b0; tick(); rst = 1'b1;
    chk("midrst_armed", armed, 0);
    chk("midrst_fire", fire, 0);
    tick();
    chk("postrst_fire", fire, 0);
    chk("postrst_count", count, 1);

    // cancel at deadline on ch2 (also cancel on IDLE while requesting)
    cnt_load = 1'b1; cnt_load_val = 40;
    tick();
    cnt_load = 1'b0;
    req_valid = 4'b0100; set_delay(2, 10); cancel = 4'b0100;
    #1 chk("ch2_ready_idle_cancel", req_ready, 4'b0100);
    tick();
    req_valid = '0; cancel = '0;
    chk("ch2_armed", armed, 4'b0100);
    for (int i = 0; i < 9; i++) tick();
    chk("ch2_cnt50", count, 50);
    cancel = 4'b0100;
    tick();
    cancel = '0;
    chk("ch2_cancel_armed", armed, 0);
    chk("ch2_cancel_nofire", fire, 0);
    tick();
    chk("ch2_cancel_nofire2", fire, 0);

    // D=0 while halted: deadline count+1, defers until counter moves
    cnt_en = 1'b0;
    req_valid = 4'b0001; set_delay(0, 0);
    #1 chk("d0_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("d0_armed", armed, 4'b0001);
    tick();
    chk("d0_halt_nofire", fire, 0);
    chk("d0_halt_count", count, 52);
    cnt_en = 1'b1;
    tick();
    chk("d0_cnt53_nofire", fire, 0);
    tick();
    chk("d0_fire", fire, 4'b0001);
    chk("d0_disarm", armed, 0);
    // re-request in the fire cycle; then halted match still fires
    req_valid = 4'b0001; set_delay(0, 2);
    #1 chk("refire_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("refire_armed", armed, 4'b0001);
    tick();
    chk("halt_cnt56", count, 56);
    cnt_en = 1'b0;
    tick();
    chk("halt_match_fire", fire, 4'b0001);
    chk("halt_count_held", count, 56);
    tick();
    chk("halt_fire_done", fire, 0);
    cnt_en = 1'b1;

    // wrap: load 2^42-2, ch1 D=4 -> deadline 2
    top_val = '1;
    top_val = top_val - CNT_W'(1);
    cnt_load = 1'b1; cnt_load_val = top_val;
    tick();
    cnt_load = 1'b0;
    req_valid = 4'b0010; set_delay(1, 4);
    #1 chk("wrap_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    chk("wrap_count0", count, 0);
    tick(); tick();
    chk("wrap_count2", count, 2);
    chk("wrap_nofire_yet", fire, 0);
    tick();
    chk("wrap_fire", fire, 4'b0010);

    // two channels on the same deadline fire together
    tick();
    req_valid = 4'b0011; set_delay(0, 3); set_delay(1, 2);
    #1 chk("multi_ready0", req_ready, 4'b0001);
    tick();
    chk("multi_ready1", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    chk("multi_cnt7", count, 7);
    tick();
    chk("multi_fire", fire, 4'b0011);
    chk("multi_disarm", armed, 0);

`ifdef TIMEBASE_PERIODIC_EN
    req_valid = 4'b1000; set_delay(3, 3);
    #1 chk("per_ready", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("per_fire3", fire[3], (k % 3 == 0) ? 1 : 0);
      chk("per_armed3", armed[3], 1);
    end
    cancel = 4'b1000;
    tick();
    cancel = '0;
    chk("per_cancel_armed", armed[3], 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("per_stopped", fire[3], 0);
    end
    req_valid = 4'b0001; set_delay(0, 0);
    #1 chk("per_d0_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("per_d0_fire", fire[0], 1);
    end
    cancel = 4'b0001;
    tick();
    cancel = '0;
    chk("per_d0_cancel_fire", fire[0], 0);
    chk("per_d0_cancel_armed", armed[0], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
